// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - CORDIC formats, atan table, K_INV shift-add terms and FSM encoding
package cordic_pkg;

   localparam int XY_W_DEF = 20;
   localparam int Z_W_DEF  = 23;
   localparam int ITER_DEF = 16;
   localparam int PI_HALF  = 2 ** (Z_W_DEF - 2);

   // round(atan(2^-i) * 2^(Z_W-1) / pi), i = 0..22
   localparam int ATAN_N = 23;
   localparam logic [Z_W_DEF-1:0] ATAN_TAB [ATAN_N] = '{
      23'd1048576, 23'd619011, 23'd327068, 23'd166025, 23'd83335, 23'd41708,
      23'd20859,   23'd10430,  23'd5215,   23'd2608,   23'd1304,  23'd652,
      23'd326,     23'd163,    23'd81,     23'd41,     23'd20,    23'd10,
      23'd5,       23'd3,      23'd1,      23'd1,      23'd0
   };

   // K_INV ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-15 - 2^-16 - 2^-20 = 0.6072531
   localparam int KINV_FRAC = 20;
   localparam int KINV_N    = 8;
   localparam int KINV_SH  [KINV_N] = '{1, 3, 6, 9, 13, 15, 16, 20};
   localparam bit KINV_NEG [KINV_N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_GAIN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational atan(2^-i) lookup shared by rotation and vectoring engines
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [4:0]         index,
   output logic [Z_W_DEF-1:0] angle
);

   always_comb begin
      angle = '0;
      if (index < 5'(ATAN_N)) angle = ATAN_TAB[index];
   end

endmodule

// File: rtl/cordic_vector_iter.sv
// rtl/cordic_vector_iter.sv - iterative vectoring CORDIC; optional CORDIC_VEC_GAIN_COMP_EN removes gain K
module cordic_vector_iter
   import cordic_pkg::*;
#(
   parameter int XY_W = XY_W_DEF,
   parameter int Z_W  = Z_W_DEF,
   parameter int ITER = ITER_DEF
) (
   input  logic                   iclk,
   input  logic                   iresetn,
   input  logic                   inCS,
   input  logic                   ivalid,
   output logic                   iready,
   input  logic signed [XY_W-1:0] ix,
   input  logic signed [XY_W-1:0] iy,
   output logic                   ovalid,
   input  logic                   oready,
   output logic signed [XY_W+1:0] omag,
   output logic signed [Z_W-1:0]  ophase
);

   localparam int M_W = XY_W + 2;
   localparam int A_W = Z_W + 1;   // extra bit: pi/2 pre-fold plus sum of atans exceeds pi
   localparam logic signed [A_W-1:0] Z_PI_H = A_W'(PI_HALF);
   localparam logic signed [A_W-1:0] Z_MAX  = A_W'(2 ** (Z_W - 1) - 1);
   localparam logic [4:0]            LAST   = 5'(ITER - 1);

   state_t                  state;
   logic [4:0]              cnt;
   logic signed [M_W-1:0]   x, y, x_sx, y_sx, x_step, y_step, mag_src, x_clamp;
   logic signed [A_W-1:0]   z, z_step, ph_src, z_sat, atan_i;
   logic [Z_W_DEF-1:0]      atan_raw;
   logic                    zero;

   cordic_atan_rom u_atan (.index(cnt), .angle(atan_raw));

   assign atan_i = A_W'(atan_raw);
   assign x_sx   = {{2{ix[XY_W-1]}}, ix};
   assign y_sx   = {{2{iy[XY_W-1]}}, iy};

   always_comb begin
      x_step = x - (y >>> cnt);
      y_step = y + (x >>> cnt);
      z_step = z - atan_i;
      if (!y[M_W-1]) begin
         x_step = x + (y >>> cnt);
         y_step = y - (x >>> cnt);
         z_step = z + atan_i;
      end
   end

`ifdef CORDIC_VEC_GAIN_COMP_EN
   logic [M_W+KINV_FRAC-1:0] acc;
   logic signed [M_W-1:0]    x_gain;

   assign mag_src = x;
   assign ph_src  = z;

   // x_clamp is non-negative, so keeping the integer part truncates toward zero
   always_comb begin
      acc = '0;
      for (int k = 0; k < KINV_N; k++) begin
         if (KINV_NEG[k]) acc = acc - ({{KINV_FRAC{1'b0}}, x_clamp} << (KINV_FRAC - KINV_SH[k]));
         else             acc = acc + ({{KINV_FRAC{1'b0}}, x_clamp} << (KINV_FRAC - KINV_SH[k]));
      end
      x_gain = acc[KINV_FRAC +: M_W];
   end
`else
   assign mag_src = x_step;
   assign ph_src  = z_step;
`endif

   always_comb begin
      x_clamp = mag_src[M_W-1] ? '0 : mag_src;
      z_sat   = ph_src;
      if (ph_src > Z_MAX)       z_sat = Z_MAX;
      else if (ph_src < -Z_MAX) z_sat = -Z_MAX;
   end

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         state  <= ST_IDLE;
         iready <= 1'b1;
         ovalid <= 1'b0;
         omag   <= '0;
         ophase <= '0;
         cnt    <= '0;
         x      <= '0;
         y      <= '0;
         z      <= '0;
         zero   <= 1'b0;
      end else if (!inCS) begin
         case (state)
            ST_IDLE: if (ivalid) begin
               iready <= 1'b0;
               cnt    <= '0;
               zero   <= (ix == '0) && (iy == '0);
               state  <= ST_ITER;
               if (!ix[XY_W-1]) begin
                  x <= x_sx;  y <= y_sx;  z <= '0;
               end else if (!iy[XY_W-1]) begin
                  x <= y_sx;  y <= -x_sx; z <= Z_PI_H;
               end else begin
                  x <= -y_sx; y <= x_sx;  z <= -Z_PI_H;
               end
            end
            ST_ITER: begin
               x   <= x_step;
               y   <= y_step;
               z   <= z_step;
               cnt <= cnt + 5'd1;
               if (cnt == LAST) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                  state  <= ST_GAIN;
`else
                  omag   <= zero ? '0 : x_clamp;
                  ophase <= zero ? '0 : z_sat[Z_W-1:0];
                  ovalid <= 1'b1;
                  state  <= ST_DONE;
`endif
               end
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            ST_GAIN: begin
               omag   <= zero ? '0 : x_gain;
               ophase <= zero ? '0 : z_sat[Z_W-1:0];
               ovalid <= 1'b1;
               state  <= ST_DONE;
            end
`endif
            ST_DONE: if (oready) begin
               ovalid <= 1'b0;
               iready <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb/tb_cordic_vector_iter.sv - self-checking bench for cordic_vector_iter against a real-valued model
module tb_cordic_vector_iter;

   localparam int  XY_W   = 20;
   localparam int  Z_W    = 23;
   localparam int  ITER   = 16;
   localparam int  PH_MAX = 4194303;
   localparam real PI     = 3.14159265358979;
`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam int  LAT  = ITER + 2;
   localparam real GAIN = 1.0;
`else
   localparam int  LAT  = ITER + 1;
   localparam real GAIN = 1.6467602581;
`endif

   logic                   iclk = 1'b0;
   logic                   iresetn = 1'b0;
   logic                   inCS = 1'b0;
   logic                   ivalid = 1'b0;
   logic                   oready = 1'b0;
   logic signed [XY_W-1:0] ix = '0;
   logic signed [XY_W-1:0] iy = '0;
   logic                   iready, ovalid;
   logic signed [XY_W+1:0] omag;
   logic signed [Z_W-1:0]  ophase;

   int checks = 0;
   int errors = 0;

   cordic_vector_iter dut (
      .iclk(iclk), .iresetn(iresetn), .inCS(inCS), .ivalid(ivalid), .iready(iready),
      .ix(ix), .iy(iy), .ovalid(ovalid), .oready(oready), .omag(omag), .ophase(ophase)
   );

   always #5 iclk = ~iclk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int model_mag(input int x, input int y);
      return int'(GAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
   endfunction

   function automatic int model_ph(input int x, input int y);
      real p;
      if (x == 0 && y == 0) return 0;
      p = $atan2(real'(y), real'(x)) * 4194304.0 / PI;
      if (p > PH_MAX) p = PH_MAX;
      if (p < -PH_MAX) p = -PH_MAX;
      return int'(p);
   endfunction

   function automatic int ph_diff(input int a, input int b);
      int d;
      d = a - b;
      if (d > 4194304) d -= 8388608;
      if (d < -4194304) d += 8388608;
      return d;
   endfunction

   // cyc = cycles from the accept cycle (inclusive) until ovalid is seen
   task automatic send(input int x, input int y, input int stall_at,
                       output int mag, output int ph, output int cyc);
      int n;
      @(negedge iclk);
      n = 0;
      while (!iready && n < 100) begin @(negedge iclk); n++; end
      checks++;
      if (!iready) begin errors++; $display("FAIL iready_wait got=0 exp=1"); end
      ix = XY_W'(x); iy = XY_W'(y); ivalid = 1'b1;
      @(posedge iclk); #1; ivalid = 1'b0;
      cyc = 1;
      while (!ovalid && cyc < 100) begin
         inCS = (stall_at >= 0) && (cyc > stall_at) && (cyc <= stall_at + 3);
         @(posedge iclk); #1; cyc++;
      end
      inCS = 1'b0;
      checks++;
      if (!ovalid) begin errors++; $display("FAIL ovalid_wait got=0 exp=1"); end
      mag = int'(omag); ph = int'(ophase);
   endtask

   task automatic consume();
      oready = 1'b1;
      @(posedge iclk); #1;
      oready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge iclk);
      @(negedge iclk);
      checks++;
      if (iready !== 1'b1 || ovalid !== 1'b0 || omag !== '0 || ophase !== '0) begin
         errors++;
         $display("FAIL reset_state got=%b/%b/%0d/%0d exp=1/0/0/0", iready, ovalid, omag, ophase);
      end
      iresetn = 1'b1;
   endtask

   task automatic test_directed();
      int vx[6] = '{100000, 0, -100000, -524288, -100000, 0};
      int vy[6] = '{0, 100000, -100000, -524288, 0, 0};
      int ep[6] = '{0, 2097152, -3145728, -3145728, PH_MAX, 0};
      int m, p, c, em;
      for (int k = 0; k < 6; k++) begin
         send(vx[k], vy[k], -1, m, p, c);
         consume();
         em = model_mag(vx[k], vy[k]);
         checks++;
         if (k == 5) begin
            if (m !== 0 || p !== 0) begin
               errors++; $display("FAIL zero_vec got=%0d/%0d exp=0/0", m, p);
            end
         end else if (k == 4) begin
            if (p > PH_MAX || p < PH_MAX - 64 || iabs(m - em) > 16) begin
               errors++; $display("FAIL sat_pi got=%0d/%0d exp=%0d/%0d", m, p, em, PH_MAX);
            end
         end else if (iabs(m - em) > 16 || iabs(ph_diff(p, ep[k])) > 64 || m < 0) begin
            errors++; $display("FAIL dir%0d got=%0d/%0d exp=%0d/%0d", k, m, p, em, ep[k]);
         end
         if (k == 0) begin
            checks++;
            if (c !== LAT) begin errors++; $display("FAIL latency got=%0d exp=%0d", c, LAT); end
         end
      end
   endtask

   task automatic test_random();
      int x, y, m, p, c, em, ep;
      for (int k = 0; k < 24; k++) begin
         do begin
            x = int'($urandom_range(0, 1048575)) - 524288;
            y = int'($urandom_range(0, 1048575)) - 524288;
         end while (real'(x) * real'(x) + real'(y) * real'(y) < 4.294967296e9);
         send(x, y, -1, m, p, c);
         consume();
         em = model_mag(x, y);
         ep = model_ph(x, y);
         checks++;
         if (iabs(m - em) > 32 || iabs(ph_diff(p, ep)) > 128) begin
            errors++;
            $display("FAIL rand x=%0d y=%0d got=%0d/%0d exp=%0d/%0d", x, y, m, p, em, ep);
         end
      end
   endtask

   task automatic test_backpressure();
      int m, p, c, pulses;
      send(150000, -70000, -1, m, p, c);
      for (int k = 0; k < 5; k++) begin
         @(negedge iclk);
         ix = XY_W'(-3000); iy = XY_W'(5000); ivalid = 1'b1;
         @(posedge iclk); #1;
         ivalid = 1'b0;
         checks++;
         if (ovalid !== 1'b1 || iready !== 1'b0 || int'(omag) != m || int'(ophase) != p) begin
            errors++;
            $display("FAIL hold%0d got=%b/%b/%0d/%0d exp=1/0/%0d/%0d", k, ovalid, iready, omag, ophase, m, p);
         end
      end
      consume();
      checks++;
      if (ovalid !== 1'b0 || iready !== 1'b1) begin
         errors++; $display("FAIL consume got=%b/%b exp=0/1", ovalid, iready);
      end
      pulses = 0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(posedge iclk); #1;
         if (ovalid) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL ghost_accept got=%0d exp=0", pulses); end
   endtask

   task automatic test_cs_stall();
      int m1, p1, c1, m2, p2, c2;
      send(-250000, 180000, -1, m1, p1, c1);
      consume();
      send(-250000, 180000, 5, m2, p2, c2);
      consume();
      checks++;
      if (c2 != c1 + 3 || m2 != m1 || p2 != p1) begin
         errors++;
         $display("FAIL cs_stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", c2, m2, p2, c1 + 3, m1, p1);
      end
   endtask

   task automatic test_reset_mid();
      int m, p, c, em;
      @(negedge iclk);
      ix = XY_W'(300000); iy = XY_W'(-200000); ivalid = 1'b1;
      @(posedge iclk); #1;
      ivalid = 1'b0;
      repeat (7) @(posedge iclk);
      #2 iresetn = 1'b0;
      #1;
      checks++;
      if (iready !== 1'b1 || ovalid !== 1'b0 || omag !== '0 || ophase !== '0) begin
         errors++;
         $display("FAIL reset_mid got=%b/%b/%0d/%0d exp=1/0/0/0", iready, ovalid, omag, ophase);
      end
      @(negedge iclk);
      iresetn = 1'b1;
      send(0, 100000, -1, m, p, c);
      consume();
      em = model_mag(0, 100000);
      checks++;
      if (iabs(m - em) > 16 || iabs(p - 2097152) > 64 || c != LAT) begin
         errors++;
         $display("FAIL after_reset got=%0d/%0d/%0d exp=%0d/2097152/%0d", m, p, c, em, LAT);
      end
   endtask

   task automatic test_back_to_back();
      int t[$];
      int n;
      @(negedge iclk);
      ix = XY_W'(200000); iy = XY_W'(123456); ivalid = 1'b1; oready = 1'b1;
      for (int c = 0; c < 4 * (LAT + 1) + 4; c++) begin
         @(posedge iclk); #1;
         if (ovalid) t.push_back(c);
      end
      ivalid = 1'b0;
      checks++;
      if (t.size() < 3) begin
         errors++; $display("FAIL b2b_count got=%0d exp=>=3", t.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (t[k] - t[k-1] != LAT + 1) begin
               errors++; $display("FAIL b2b_period got=%0d exp=%0d", t[k] - t[k-1], LAT + 1);
            end
         end
      end
      n = 0;
      while (!(iready && !ovalid) && n < 3 * LAT) begin @(posedge iclk); #1; n++; end
      oready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_cs_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
